// File: rtl/ask_pkg.sv
// Shared constants, state encoding and sizing helper for the ASK modulator.
package ask_pkg;

    localparam int unsigned CW = 7;
    localparam int unsigned AW = 7;
    localparam int unsigned OW = 14;

    localparam int unsigned BitCyclesDef = 5000;
    localparam int unsigned AmpHiDef     = 127;
    localparam int unsigned AmpLoDef     = 0;

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ask_modulator_if.sv
// Byte-stream handshake between the upstream data source and the modulator.
interface ask_modulator_if;

    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;

    modport master (output byte_in, output byte_valid, input byte_ready);
    modport slave  (input byte_in, input byte_valid, output byte_ready);

endinterface

// File: rtl/bit_serializer.sv
// Byte-to-bit serializer: holds each bit MSB-first for BIT_CYCLES clocks, with gapless reload.
module bit_serializer
    import ask_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = BitCyclesDef
) (
    input  logic             clk,
    input  logic             rst,
    ask_modulator_if.slave   bus,
    output logic             cur_bit,
    output logic             busy
);

    localparam int unsigned     CntW    = cnt_width(BIT_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(BIT_CYCLES - 1);

    state_e          state_q, state_d;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      idx_q, idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            shift_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        ready   = 1'b0;
        busy    = 1'b0;
        cur_bit = 1'b0;
        case (state_q)
            StIdle: begin
                ready = !rst;
            end
            StShift: begin
                busy    = 1'b1;
                cur_bit = shift_q[7];
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    shift_d = {shift_q[6:0], 1'b0};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        // Last cycle of the byte: a waiting byte follows with no idle gap.
                        ready = !rst;
                        if (!bus.byte_valid) begin
                            state_d = StIdle;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (ready && bus.byte_valid) begin
            state_d = StShift;
            shift_d = bus.byte_in;
            idx_d   = '0;
            cnt_d   = '0;
        end
    end

    assign bus.byte_ready = ready;

endmodule

// File: rtl/ask_modulator.sv
// AM-ASK/OOK modulator: scales the free-running carrier by a per-bit amplitude through a
// two-stage register pipeline so mod_out and bit_out stay time-aligned.
module ask_modulator
    import ask_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = BitCyclesDef,
    parameter int unsigned AMP_HI     = AmpHiDef,
    parameter int unsigned AMP_LO     = AmpLoDef
) (
    input  logic                 clk,
    input  logic                 rst,
    ask_modulator_if.slave       bus,
    input  logic signed [CW-1:0] carrier_in,
    output logic signed [OW-1:0] mod_out,
    output logic                 bit_out,
    output logic                 busy
);

    localparam logic [AW-1:0] AmpHiW = AW'(AMP_HI);
    localparam logic [AW-1:0] AmpLoW = AW'(AMP_LO);

    logic                 cur_bit;
    logic [AW-1:0]        amp;
    logic signed [CW-1:0] carrier_q;
    logic [AW-1:0]        amp_q;
    logic                 bit_s1_q;
    logic signed [OW-1:0] carrier_ext, amp_ext, prod;
    logic signed [OW-1:0] mod_q;
    logic                 bit_q;

    bit_serializer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_serializer (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .cur_bit(cur_bit),
        .busy   (busy)
    );

    // cur_bit is forced low when idle, so idle naturally selects AMP_LO.
    assign amp = cur_bit ? AmpHiW : AmpLoW;

    // Signed carrier times zero-extended amplitude; fits in OW bits without loss.
    always_comb begin
        carrier_ext = {{(OW - CW){carrier_q[CW-1]}}, carrier_q};
        amp_ext     = {{(OW - AW){1'b0}}, amp_q};
        prod        = carrier_ext * amp_ext;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            carrier_q <= '0;
            amp_q     <= '0;
            bit_s1_q  <= 1'b0;
            mod_q     <= '0;
            bit_q     <= 1'b0;
        end else begin
            carrier_q <= carrier_in;
            amp_q     <= amp;
            bit_s1_q  <= cur_bit;
            mod_q     <= prod;
            bit_q     <= bit_s1_q;
        end
    end

    assign mod_out = mod_q;
    assign bit_out = bit_q;

endmodule

// File: tb/tb_ask_modulator.sv
// Bench for ask_modulator: OOK and AM-ASK instances driven in lockstep, checked each cycle
// against a byte-timeline reference model.
module tb_ask_modulator;
    import ask_pkg::*;

    localparam int BC    = 4;
    localparam int AHI   = 127;
    localparam int ALO_B = 20;

    logic                 clk;
    logic                 rst;
    logic signed [CW-1:0] carrier;
    logic signed [OW-1:0] mod_a, mod_b;
    logic                 bit_a, bit_b, busy_a, busy_b;

    ask_modulator_if bus_a ();
    ask_modulator_if bus_b ();

    ask_modulator #(.BIT_CYCLES(BC), .AMP_HI(AHI), .AMP_LO(0)) u_dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .carrier_in(carrier),
        .mod_out(mod_a), .bit_out(bit_a), .busy(busy_a)
    );

    ask_modulator #(.BIT_CYCLES(BC), .AMP_HI(AHI), .AMP_LO(ALO_B)) u_dut_b (
        .clk(clk), .rst(rst), .bus(bus_b), .carrier_in(carrier),
        .mod_out(mod_b), .bit_out(bit_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: cycles left in the current byte and the byte itself; outputs follow by arithmetic.
    int         m_left = 0;
    logic [7:0] m_byte = 8'h00;
    bit         m_accept = 0;
    int         m_acc_cycle = 0;
    int         a1 = 0, a2 = 0, b1 = 0, b2 = 0;
    bit         d1 = 0, d2 = 0;
    int         busy_seen = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic cycle(input bit r, input bit v, input logic [7:0] b, input int car);
        int   elapsed;
        bit   e_busy, e_ready, e_bit;
        int   amp_a, amp_b;
        logic [6:0] car7;
        @(negedge clk);
        car7 = car[6:0];
        rst = r;
        carrier = car7;
        bus_a.byte_valid = v;
        bus_a.byte_in = b;
        bus_b.byte_valid = v;
        bus_b.byte_in = b;
        #1;
        e_busy  = (m_left > 0);
        e_ready = !r && (m_left <= 1);
        elapsed = 8 * BC - m_left;
        e_bit   = e_busy ? m_byte[7 - elapsed / BC] : 1'b0;
        amp_a   = e_bit ? AHI : 0;
        amp_b   = e_bit ? AHI : ALO_B;
        check_eq("mod_a", mod_a, a2);
        check_eq("mod_b", mod_b, b2);
        check_eq("bit_a", bit_a, d2);
        check_eq("bit_b", bit_b, d2);
        check_eq("busy", busy_a, e_busy);
        check_eq("ready_a", bus_a.byte_ready, e_ready);
        check_eq("ready_b", bus_b.byte_ready, e_ready);
        if (busy_a) busy_seen++;
        @(posedge clk);
        cyc++;
        m_accept = 0;
        if (r) begin
            m_left = 0;
            a1 = 0; a2 = 0; b1 = 0; b2 = 0; d1 = 0; d2 = 0;
        end else begin
            a2 = a1; b2 = b1; d2 = d1;
            a1 = car * amp_a;
            b1 = car * amp_b;
            d1 = e_bit;
            if (v && e_ready) begin
                m_byte = b;
                m_left = 8 * BC;
                m_accept = 1;
                m_acc_cycle = cyc;
            end else if (m_left > 0) begin
                m_left--;
            end
        end
    endtask

    task automatic idle(input int n, input int car);
        for (int i = 0; i < n; i++) cycle(0, 0, 8'h00, car);
    endtask

    task automatic send_byte(input logic [7:0] b, input int car);
        int k;
        k = 0;
        do begin
            cycle(0, 1, b, car);
            k++;
        end while (!m_accept && k < 100);
        if (!m_accept) check_eq("accept_timeout", 0, 1);
    endtask

    initial begin
        int t1, acc_cnt;
        rst = 1'b1;
        carrier = '0;
        bus_a.byte_valid = 1'b0; bus_a.byte_in = '0;
        bus_b.byte_valid = 1'b0; bus_b.byte_in = '0;
        repeat (2) @(posedge clk);

        // Reset and idle
        for (int i = 0; i < 3; i++) cycle(1, 0, 8'h00, 63);
        idle(5, 63);

        // Single byte 0xA5
        busy_seen = 0;
        send_byte(8'hA5, 10);
        idle(40, 10);
        check_eq("busy_len", busy_seen, 8 * BC);

        // Back-to-back: 0x00 waiting right behind 0xFF
        send_byte(8'hFF, 10);
        t1 = m_acc_cycle;
        send_byte(8'h00, 10);
        check_eq("b2b_gap", m_acc_cycle - t1, 8 * BC);
        idle(40, 10);

        // Extreme values
        send_byte(8'h80, -64);
        idle(2, -64);
        #1;
        check_eq("ext_hi_a", mod_a, -8128);
        check_eq("ext_hi_b", mod_b, -8128);
        idle(4, -64);
        #1;
        check_eq("ext_lo_a", mod_a, 0);
        check_eq("ext_lo_b", mod_b, -1280);
        idle(40, -64);

        // Valid ignored mid-byte
        send_byte(8'h5A, 33);
        idle(8, 33);
        acc_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, 8'h3C, 33);
            if (m_accept) acc_cnt++;
        end
        check_eq("ignored_accepts", acc_cnt, 0);
        idle(40, 33);

        // Reset during bit 3
        send_byte(8'hF0, 50);
        idle(3 * BC + 1, 50);
        cycle(1, 0, 8'h00, 50);
        #1;
        check_eq("rst_mid_busy", busy_a, 0);
        idle(2, 50);
        #1;
        check_eq("rst_mid_mod", mod_a, 0);
        send_byte(8'h81, 50);
        idle(40, 50);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0),
                  8'($urandom), int'($urandom_range(0, 127)) - 64);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
